// File: rtl/cmd_arb_pkg.sv
// Shared constants, entry layout, FSM encoding and round-robin helper for the
// register-write command arbiter.
package cmd_arb_pkg;

   localparam int CMD_ADDR_W  = 8;
   localparam int CMD_DATA_W  = 32;
   localparam int CMD_ENTRY_W = CMD_ADDR_W + CMD_DATA_W;
   localparam int CMD_SRC_W   = 2;
   localparam int MAX_SRC     = 4;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] data;
   } cmd_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Returns {found, index}: first requester after `last`, wrapping modulo num_src.
   function automatic logic [CMD_SRC_W:0] rr_pick(
      input logic [MAX_SRC-1:0]   req,
      input logic [CMD_SRC_W-1:0] last,
      input int                   num_src
   );
      logic [CMD_SRC_W:0] result;
      int                 idx;
      result = '0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         idx = (int'(last) + k) % num_src;
         if ((k <= num_src) && !result[CMD_SRC_W] && req[idx[CMD_SRC_W-1:0]]) begin
            result = {1'b1, idx[CMD_SRC_W-1:0]};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/cmd_arb_fifo.sv
// Per-source command queue: DEPTH entries, combinational head, and a push on a
// full queue is accepted only when the head is popped in the same cycle.
module cmd_arb_fifo
   import cmd_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_ENTRY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int                 PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which
   // entries are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin merge of fire-and-forget command sources onto one valid/ready
// register-write bus. Define CMD_ARB_TIMEOUT_EN to drop commands stalled too long.
module cmd_arbiter
   import cmd_arb_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*CMD_ADDR_W-1:0] src_addr,
   input  logic [NUM_SRC*CMD_DATA_W-1:0] src_data,
   input  logic                          ovf_clr,
   output logic [NUM_SRC-1:0]            src_overflow,
   output logic                          wr_valid,
   input  logic                          wr_ready,
   output logic [CMD_ADDR_W-1:0]         wr_addr,
   output logic [CMD_DATA_W-1:0]         wr_data,
   output logic [CMD_SRC_W-1:0]          wr_src,
   output logic                          timeout_err
);

   arb_state_e             state;
   arb_state_e             state_next;
   logic [CMD_SRC_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0]     q_empty;
   logic [NUM_SRC-1:0]     q_full;
   logic [NUM_SRC-1:0]     q_pop;
   logic [NUM_SRC-1:0]     q_drop;
   cmd_entry_t             q_head [NUM_SRC];
   logic [MAX_SRC-1:0]     req;
   logic [CMD_SRC_W:0]     pick;
   logic                   found;
   logic [CMD_SRC_W-1:0]   grant_src;
   logic                   grant_slot;
   logic                   grant;
   cmd_entry_t             grant_entry;
   logic                   expire;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      cmd_entry_t push_entry;

      assign push_entry = '{addr: src_addr[i*CMD_ADDR_W +: CMD_ADDR_W],
                            data: src_data[i*CMD_DATA_W +: CMD_DATA_W]};
      assign q_pop[i]   = grant && (grant_src == CMD_SRC_W'(i));
      assign q_drop[i]  = src_valid[i] && q_full[i] && !q_pop[i];

      cmd_arb_fifo #(
         .DEPTH (QDEPTH),
         .WIDTH (CMD_ENTRY_W)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (src_valid[i]),
         .push_data (push_entry),
         .pop       (q_pop[i]),
         .head      (q_head[i]),
         .empty     (q_empty[i]),
         .full      (q_full[i])
      );
   end

   assign pick      = rr_pick(req, rr_ptr, NUM_SRC);
   assign found     = pick[CMD_SRC_W];
   assign grant_src = pick[CMD_SRC_W-1:0];

   // A new grant is allowed from IDLE, or from BUSY once the held command
   // leaves the bus by handshake or by timeout.
   assign grant_slot = (state == IDLE) || wr_ready || expire;
   assign grant      = grant_slot && found;

   // NOTE: every always_comb output gets a default before any branch so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      req                = '0;
      req[NUM_SRC-1:0]   = ~q_empty;
      grant_entry        = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_src == CMD_SRC_W'(i)) grant_entry = q_head[i];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = BUSY;
         BUSY:    if (wr_ready || expire) state_next = found ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= CMD_SRC_W'(NUM_SRC - 1);
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_src       <= '0;
         src_overflow <= '0;
      end else begin
         state <= state_next;
         if (grant) begin
            rr_ptr  <= grant_src;
            wr_addr <= grant_entry.addr;
            wr_data <= grant_entry.data;
            wr_src  <= grant_src;
         end
         // A fresh overflow in the clearing cycle survives the clear.
         src_overflow <= (src_overflow & ~{NUM_SRC{ovf_clr}}) | q_drop;
      end
   end

   assign wr_valid = (state == BUSY);

`ifdef CMD_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;

   // tmo_cnt holds the number of completed stalled cycles of the current command.
   assign expire = (state == BUSY) && !wr_ready && (tmo_cnt == TMO_W'(TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (grant || (state_next == IDLE)) begin
         tmo_cnt <= '0;
      end else if ((state == BUSY) && !wr_ready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   // Without the timeout the bus waits forever; TIMEOUT has no effect here.
   assign expire = 1'b0 && (TIMEOUT > 0);
`endif

   assign timeout_err = expire;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: vector table plus hand-written sequences,
// with a scoreboard of expected commands checked at every bus transfer.
module tb_cmd_arbiter;
   import cmd_arb_pkg::*;

   localparam int NUM_SRC = 2;
   localparam int QDEPTH  = 4;
   localparam int TIMEOUT = 8;
`ifdef CMD_ARB_TIMEOUT_EN
   localparam int BP_CYC  = TIMEOUT;
`else
   localparam int BP_CYC  = 10;
`endif

   logic                          clk = 1'b0;
   logic                          reset;
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC*CMD_ADDR_W-1:0] src_addr;
   logic [NUM_SRC*CMD_DATA_W-1:0] src_data;
   logic                          ovf_clr;
   logic [NUM_SRC-1:0]            src_overflow;
   logic                          wr_valid;
   logic                          wr_ready;
   logic [CMD_ADDR_W-1:0]         wr_addr;
   logic [CMD_DATA_W-1:0]         wr_data;
   logic [CMD_SRC_W-1:0]          wr_src;
   logic                          timeout_err;

   cmd_arbiter #(
      .NUM_SRC (NUM_SRC),
      .QDEPTH  (QDEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .src_valid    (src_valid),
      .src_addr     (src_addr),
      .src_data     (src_data),
      .ovf_clr      (ovf_clr),
      .src_overflow (src_overflow),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_src       (wr_src),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int hs_count = 0;

   cmd_entry_t     exp_q [NUM_SRC][$];
   logic [1:0]     hs_src [$];
   int             hs_cyc [$];

   typedef struct {
      int          src;
      logic [7:0]  addr;
      logic [31:0] data;
      int          stall;
      logic [1:0]  exp_src;
   } vec_t;

   vec_t vecs [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic [7:0] a, input logic [31:0] d, input bit accept);
      src_valid[s]        = 1'b1;
      src_addr[8*s +: 8]  = a;
      src_data[32*s +: 32] = d;
      if (accept) exp_q[s].push_back('{addr: a, data: d});
   endtask

   task automatic clr_src();
      src_valid = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clr_src();
      wr_ready = 1'b0;
      ovf_clr = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         @(negedge clk);
         done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && !wr_valid;
      end
      check(name, 64'(done), 64'd1);
      step();
   endtask

   // Scoreboard: every command leaving the bus (handshake or timeout drop).
   always @(negedge clk) begin : mon
      int s;
      cmd_entry_t e;
      if (!reset && wr_valid && (wr_ready || timeout_err)) begin
         s = int'(wr_src);
         hs_count++;
         hs_src.push_back(wr_src);
         hs_cyc.push_back(cyc);
         if (s >= NUM_SRC || exp_q[s].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got src %0d addr 0x%0h, expected no command", s, wr_addr);
         end else begin
            e = exp_q[s].pop_front();
            check("sb_addr", 64'(wr_addr), 64'(e.addr));
            check("sb_data", 64'(wr_data), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int hs0;
      int hit;

      vecs[0] = '{src: 0, addr: 8'h10, data: 32'hDEAD_BEEF, stall: 0, exp_src: 2'd0};
      vecs[1] = '{src: 1, addr: 8'h20, data: 32'h1234_5678, stall: 0, exp_src: 2'd1};
      vecs[2] = '{src: 1, addr: 8'hFF, data: 32'hFFFF_FFFF, stall: 3, exp_src: 2'd1};
      vecs[3] = '{src: 0, addr: 8'h00, data: 32'h0000_0000, stall: 2, exp_src: 2'd0};

      src_addr = '0;
      src_data = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      check("rst_wr_src", 64'(wr_src), 64'd0);
      check("rst_overflow", 64'(src_overflow), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      step();

      // Single commands: two-cycle latency, payload, optional stall, one-cycle valid
      foreach (vecs[v]) begin
         wr_ready = (vecs[v].stall == 0);
         set_src(vecs[v].src, vecs[v].addr, vecs[v].data, 1'b1);
         step();
         clr_src();
         @(negedge clk);
         check("vec_lat_early", 64'(wr_valid), 64'd0);
         step();
         for (int j = 0; j < vecs[v].stall; j++) begin
            @(negedge clk);
            check("vec_stall_hold", {wr_valid, wr_addr, wr_data},
                  {23'd0, 1'b1, vecs[v].addr, vecs[v].data});
            step();
         end
         wr_ready = 1'b1;
         @(negedge clk);
         check("vec_valid", 64'(wr_valid), 64'd1);
         check("vec_addr", 64'(wr_addr), 64'(vecs[v].addr));
         check("vec_data", 64'(wr_data), 64'(vecs[v].data));
         check("vec_src", 64'(wr_src), 64'(vecs[v].exp_src));
         step();
         @(negedge clk);
         check("vec_one_cycle", 64'(wr_valid), 64'd0);
         step();
      end

      // Fairness: 3 simultaneous pushes on both sources -> 0,1,0,1,0,1 back-to-back
      do_reset();
      wr_ready = 1'b1;
      base = hs_src.size();
      for (int n = 0; n < 3; n++) begin
         set_src(0, 8'h30 + 8'(n), 32'h3000_0000 + 32'(n), 1'b1);
         set_src(1, 8'h40 + 8'(n), 32'h4000_0000 + 32'(n), 1'b1);
         step();
      end
      clr_src();
      for (int t = 0; t < 30 && hs_src.size() < base + 6; t++) step();
      check("fair_count", 64'(hs_src.size() - base), 64'd6);
      for (int i = 0; i < 6; i++) check("fair_order", 64'(hs_src[base + i]), 64'(i % 2));
      for (int i = 1; i < 6; i++) check("fair_no_gap", 64'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 64'd1);
      wait_drain("fair_drain");

      // Backpressure: payload stable while stalled, then handshake and next command
      do_reset();
      set_src(0, 8'hA1, 32'hA1A1_0001, 1'b1);
      set_src(1, 8'hB2, 32'hB2B2_0002, 1'b1);
      step();
      clr_src();
      step();
      for (int c = 0; c < BP_CYC; c++) begin
         @(negedge clk);
         check("bp_hold", {wr_valid, wr_addr, wr_data}, {23'd0, 1'b1, 8'hA1, 32'hA1A1_0001});
         step();
      end
      wr_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {wr_valid, timeout_err, wr_addr}, {54'd0, 1'b1, 1'b0, 8'hA1});
      step();
      @(negedge clk);
      check("bp_next", {wr_valid, wr_src, wr_addr}, {53'd0, 1'b1, 2'd1, 8'hB2});
      wait_drain("bp_drain");

      // Overflow: bus stalled on source 0, six pushes on source 1 keep only four
      do_reset();
      set_src(0, 8'h55, 32'h5555_0000, 1'b1);
      step();
      clr_src();
      hs0 = hs_count;
      for (int n = 0; n < 6; n++) begin
         set_src(1, 8'h60 + 8'(n), 32'h6000_0000 + 32'(n), n < 4);
         step();
         clr_src();
         if (n == 3) begin
            @(negedge clk);
            check("ovf_not_yet", 64'(src_overflow), 64'd0);
         end
      end
      @(negedge clk);
      check("ovf_set", 64'(src_overflow), 64'b10);
      wr_ready = 1'b1;
      wait_drain("ovf_drain");
      check("ovf_delivered", 64'(hs_count - hs0), 64'd5);
      check("ovf_sticky", 64'(src_overflow), 64'b10);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 64'(src_overflow), 64'd0);
      step();

      // Timeout / indefinite wait
      do_reset();
      set_src(0, 8'h71, 32'h7100_0001, 1'b1);
      step();
      set_src(0, 8'h72, 32'h7200_0002, 1'b1);
      step();
      clr_src();
`ifdef CMD_ARB_TIMEOUT_EN
      hit = 0;
      for (int c = 1; c <= 20 && hit == 0; c++) begin
         @(negedge clk);
         if (timeout_err) begin
            hit = c;
            check("tmo_drop_addr", 64'(wr_addr), 64'h71);
         end else begin
            step();
         end
      end
      check("tmo_cycle", 64'(hit), 64'(TIMEOUT + 1));
      step();
      @(negedge clk);
      check("tmo_next", {wr_valid, timeout_err, wr_addr}, {54'd0, 1'b1, 1'b0, 8'h72});
      step();
`else
      hit = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("tmo_off_hold", {wr_valid, timeout_err, wr_addr}, {54'd0, 1'b1, 1'b0, 8'h71});
         step();
      end
`endif
      wr_ready = 1'b1;
      wait_drain("tmo_drain");

      // Reset mid-transfer drops held and queued commands
      do_reset();
      set_src(0, 8'h81, 32'h8100_0000, 1'b0);
      set_src(1, 8'h82, 32'h8200_0000, 1'b0);
      step();
      set_src(0, 8'h83, 32'h8300_0000, 1'b0);
      step();
      clr_src();
      @(negedge clk);
      check("rstmid_busy", 64'(wr_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_valid_drop", 64'(wr_valid), 64'd0);
      step();
      step();
      reset = 1'b0;
      wr_ready = 1'b1;
      hs0 = hs_count;
      for (int t = 0; t < 10; t++) step();
      check("rstmid_no_delivery", 64'(hs_count - hs0), 64'd0);
      @(negedge clk);
      check("rstmid_idle", 64'(wr_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmd_arbiter.md
# cmd_arbiter

Merges register-write commands from several independent command decoders (Ethernet command parser, UART command parser, etc.) onto the single register-write bus of the debugger's control plane. Each source issues fire-and-forget one-cycle `cmdvalid` pulses with address/data and has no backpressure. The arbiter therefore buffers each source in a small queue, picks among the queues round-robin, and presents one command at a time on a valid/ready bus towards the register file.

## Interface
Parameters:
- `NUM_SRC`, 2: number of command sources (2..4).
- `QDEPTH`, 4: entries per source queue; power of two, ≥2.
- `TIMEOUT`, 255: cycles `wr_valid` may wait for `wr_ready` before the command is dropped (only with `CMD_ARB_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `src_valid` in NUM_SRC: per-source one-cycle command strobe.
- `src_addr` in NUM_SRC*8: per-source address; source i at [8i+7:8i].
- `src_data` in NUM_SRC*32: per-source data; source i at [32i+31:32i].
- `ovf_clr` in 1: clears all `src_overflow` bits.
- `src_overflow` out NUM_SRC: sticky; set when a command is dropped on a full queue.
- `wr_valid` out 1: command on bus.
- `wr_ready` in 1: register file accepts.
- `wr_addr` out 8, `wr_data` out 32, `wr_src` out 2: command and originating source index.
- `timeout_err` out 1: one-cycle pulse when a command is dropped by timeout.

## Operation
- Reset values: all outputs 0, queues empty, RR pointer = NUM_SRC-1 (source 0 wins first), FSM in IDLE, timeout counter 0.
- Queue push: `src_valid[i]` at an edge writes {addr,data} into queue i.
  - If queue i is full and is not popped in the same cycle, the command is discarded and `src_overflow[i]` is set.
  - If queue i is full and popped in the same cycle, the push is accepted and the count is unchanged.
- `ovf_clr` clears the overflow bits. If it coincides with a new overflow, the set wins.
- Arbitration: round-robin search over non-empty queues, starting at (last granted + 1) mod NUM_SRC. The grant pops the queue, loads `wr_addr/wr_data/wr_src`, and updates the pointer.
- FSM states:
  - IDLE: `wr_valid`=0. If any queue is non-empty, grant, go to BUSY.
  - BUSY: `wr_valid`=1, outputs held stable while `wr_ready`=0.
    - On `wr_ready`=1: if any queue is non-empty, grant in the same cycle and stay in BUSY (back-to-back); otherwise go to IDLE.
    - On timeout expiry: drop the held command, pulse `timeout_err`, and re-arbitrate exactly as on `wr_ready`.
- Bus rule: `wr_valid` never drops without a handshake or timeout. Payload changes only after a handshake or timeout.
- Reset asserted mid-transfer: the held command and all queued commands are lost; `wr_valid` deasserts immediately.

## Timing
- `src_valid` at edge k → queue entry valid after k → `wr_valid` high after edge k+1 (2-cycle latency with the bus idle and no competing source).
- Throughput: 1 command/cycle when `wr_ready` is held high.
- Fairness: with all queues non-empty, the grant sequence is 0,1,..,NUM_SRC-1 repeating.
- Timeout counter:
  - Counts cycles in BUSY with `wr_ready`=0; cleared on each grant.
  - Expiry when the count reaches TIMEOUT, i.e. after TIMEOUT stalled cycles.
  - `wr_ready`=1 in the expiry cycle counts as a normal handshake, with no `timeout_err`.

## Configuration
- `CMD_ARB_TIMEOUT_EN` defined: timeout counter, drop, and `timeout_err` pulse are implemented.
- Not defined: the arbiter waits indefinitely for `wr_ready`; `timeout_err` is tied to 0; the `TIMEOUT` parameter is ignored. The port list is identical in both builds.

## Structure
- Package `cmd_arb_pkg`:
  - `CMD_ADDR_W`=8 and `CMD_DATA_W`=32.
  - Entry width constant (40).
  - FSM state encoding (IDLE, BUSY).
- Sub-module `cmd_arb_fifo`: one instance per source.
  - Synchronous QDEPTH×40 queue with push, pop, empty, full and same-cycle push/pop on full as above.
  - Read data is combinational from the head.

## Test plan
- Single command: source 0 pulses addr 0x10, data 0xDEADBEEF, `wr_ready`=1 → `wr_valid` 2 cycles later with 0x10/0xDEADBEEF/`wr_src`=0 for exactly 1 cycle.
- Fairness: both sources push 3 commands each in the same cycles, `wr_ready`=1 → bus order src 0,1,0,1,0,1, with no gaps.
- Backpressure: `wr_ready`=0 for 10 cycles → payload stable for all 10 cycles; handshake on cycle 11 then the next command.
- Overflow: QDEPTH=4, `wr_ready`=0, 6 pushes on source 1 → `src_overflow[1]`=1, only the first 4 commands are delivered after `wr_ready` rises; `ovf_clr` clears the bit.
- Timeout (macro on, TIMEOUT=8): `wr_ready` held 0 → `timeout_err` pulses after 8 stalled cycles, the next queued command appears the following cycle. Macro off: `wr_valid` held, no pulse.
- Reset mid-transfer: assert `reset` while in BUSY with queued entries → `wr_valid`=0 immediately, and no commands are delivered after release.
